// File: rtl/mem_ctrl_banked.sv
// Banked data-memory controller: accumulator, STATUS (Z, C, bank select) and banked RAM.
// Optional macro COMMON_RAM_EN maps 0xF0-0xFF to bank 0 regardless of bank select.
module mem_ctrl_banked #(
    parameter int BANK_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       zin,
    input  logic       z_write,
    input  logic       cin,
    input  logic       c_write,
    output logic       cout,
    input  logic [7:0] writeaddr,
    input  logic [7:0] writedata,
    input  logic       write_en,
    input  logic [7:0] readaddr,
    output logic [7:0] readdata,
    input  logic       accum_write,
    output logic [7:0] accum_out
);

    localparam int NBANK = 1 << BANK_BITS;
    localparam int IDX_W = BANK_BITS + 8;

    logic [7:0]           r_ram [0:NBANK*256-1];
    logic [7:0]           r_acc;
    logic                 r_z;
    logic                 r_c;
    logic [BANK_BITS-1:0] r_bank;

    logic                 w_wr_acc;
    logic                 w_wr_status;
    logic                 w_wr_ram;
    logic [BANK_BITS-1:0] w_wr_bank;
    logic [BANK_BITS-1:0] w_rd_bank;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [7:0]           w_status;

    assign w_wr_acc    = write_en && (writeaddr == 8'h00);
    assign w_wr_status = write_en && (writeaddr == 8'h01);
    assign w_wr_ram    = write_en && (writeaddr >= 8'h02);

`ifdef COMMON_RAM_EN
    // Top 16 bytes form a common window that always lives in bank 0.
    assign w_wr_bank = (writeaddr[7:4] == 4'hF) ? '0 : r_bank;
    assign w_rd_bank = (readaddr[7:4]  == 4'hF) ? '0 : r_bank;
`else
    assign w_wr_bank = r_bank;
    assign w_rd_bank = r_bank;
`endif

    assign w_wr_idx = {w_wr_bank, writeaddr};
    assign w_rd_idx = {w_rd_bank, readaddr};

    always_comb begin
        w_status                  = 8'h00;
        w_status[0]               = r_z;
        w_status[1]               = r_c;
        w_status[4+BANK_BITS:5]   = r_bank;
    end

    // Flag inputs are applied after the STATUS byte write so they take priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            r_bank <= '0;
            r_acc  <= 8'h00;
        end else begin
            if (w_wr_status) begin
                r_z    <= writedata[0];
                r_c    <= writedata[1];
                r_bank <= writedata[4+BANK_BITS:5];
            end
            if (z_write) r_z <= zin;
            if (c_write) r_c <= cin;
            if (accum_write || w_wr_acc) r_acc <= writedata;
        end
    end

    // RAM is never cleared, but reset still blocks a same-cycle store.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ram) r_ram[w_wr_idx] <= writedata;
    end

    always_comb begin
        readdata = r_ram[w_rd_idx];
        if (readaddr == 8'h00)      readdata = r_acc;
        else if (readaddr == 8'h01) readdata = w_status;
    end

    assign cout      = r_c;
    assign accum_out = r_acc;

endmodule

// File: tb/tb_mem_ctrl_banked.sv
// Scoreboard bench for mem_ctrl_banked: directed plan followed by randomized traffic against a byte-level model.
module tb_mem_ctrl_banked;

    localparam int BB    = 2;
    localparam int NBANK = 1 << BB;

    logic       clk = 1'b0;
    logic       rst_n, zin, z_write, cin, c_write, cout;
    logic [7:0] writeaddr, writedata, readaddr, readdata, accum_out;
    logic       write_en, accum_write;

    mem_ctrl_banked #(.BANK_BITS(BB)) dut (
        .clk(clk), .rst_n(rst_n), .zin(zin), .z_write(z_write), .cin(cin), .c_write(c_write),
        .cout(cout), .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
        .readaddr(readaddr), .readdata(readdata), .accum_write(accum_write), .accum_out(accum_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rd;
        bit         rd_known;
        logic       c;
        logic [7:0] acc;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference state: STATUS as a byte, RAM as a sparse map of physical byte index.
    logic [7:0] m_status, m_acc;
    logic [7:0] m_mem [int];
    bit         m_ok = 0;

    function automatic logic [7:0] status_mask();
        return 8'h03 | 8'(((1 << BB) - 1) << 5);
    endfunction

    function automatic int phys(input logic [7:0] a);
        int bank;
        bank = (m_status >> 5) & (NBANK - 1);
`ifdef COMMON_RAM_EN
        if (a >= 8'hF0) bank = 0;
`endif
        return bank * 256 + int'(a);
    endfunction

    task automatic cyc(input logic rn, input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic [7:0] ra, input logic zw, input logic zi, input logic cw,
                       input logic ci, input logic aw);
        exp_t       e;
        logic [7:0] ns;
        int         p;
        rst_n = rn; write_en = we; writeaddr = wa; writedata = wd; readaddr = ra;
        z_write = zw; zin = zi; c_write = cw; cin = ci; accum_write = aw;
        if (m_ok) begin
            e.rd_known = 1;
            if (ra == 8'h00)      e.rd = m_acc;
            else if (ra == 8'h01) e.rd = m_status;
            else begin
                p = phys(ra);
                e.rd_known = m_mem.exists(p);
                e.rd = e.rd_known ? m_mem[p] : 8'h00;
            end
            e.c   = m_status[1];
            e.acc = m_acc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!rn) begin
            m_status = 8'h00;
            m_acc    = 8'h00;
            m_ok     = 1;
        end else begin
            ns = m_status;
            if (we && wa == 8'h01) ns = wd & status_mask();
            if (zw) ns[0] = zi;
            if (cw) ns[1] = ci;
            if (aw || (we && wa == 8'h00)) m_acc = wd;
            if (we && wa >= 8'h02) m_mem[phys(wa)] = wd;
            m_status = ns;
        end
    endtask

    task automatic wr(input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ra);
        cyc(1, 1, wa, wd, ra, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [7:0] ra);
        cyc(1, 0, 8'h00, 8'h00, ra, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the read port and register outputs are always presented, so compare once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.rd_known) begin
                n_cmp++;
                if (readdata !== e.rd) begin
                    n_bad++;
                    $display("FAIL readdata @%0t addr=%02h: got %02h expected %02h", $time, readaddr, readdata, e.rd);
                end
            end
            n_cmp++;
            if (cout !== e.c) begin
                n_bad++;
                $display("FAIL cout @%0t: got %0b expected %0b", $time, cout, e.c);
            end
            n_cmp++;
            if (accum_out !== e.acc) begin
                n_bad++;
                $display("FAIL accum_out @%0t: got %02h expected %02h", $time, accum_out, e.acc);
            end
        end
    end

    function automatic logic [7:0] pick_addr();
        logic [7:0] pool [10];
        int         k;
        pool = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h7F, 8'hEF, 8'hF0, 8'hF5, 8'hFF};
        k = $urandom_range(0, 10);
        if (k == 10) return 8'($urandom);
        return pool[k];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        rst_n = 0; write_en = 0; writeaddr = 0; writedata = 0; readaddr = 0;
        z_write = 0; zin = 0; c_write = 0; cin = 0; accum_write = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0);
        rd(8'h01);
        rd(8'h00);

        wr(8'h10, 8'd32, 8'h10);
        rd(8'h10);
        wr(8'h10, 8'd31, 8'h10);
        rd(8'h10);

        wr(8'h01, 8'b0010_0010, 8'h01);
        rd(8'h01);
        wr(8'h10, 8'd12, 8'h10);
        rd(8'h10);
        wr(8'h01, 8'h00, 8'h10);
        rd(8'h10);
        wr(8'h01, 8'b0010_0000, 8'h10);
        rd(8'h10);

        cyc(1, 0, 0, 0, 8'h01, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 8'h01, 1, 1, 0, 0, 0);
        rd(8'h01);
        wr(8'h01, 8'hFF, 8'h01);
        rd(8'h01);

        cyc(1, 1, 8'h01, 8'h00, 8'h01, 0, 0, 1, 1, 0);
        rd(8'h01);

        cyc(1, 1, 8'h00, 8'd99, 8'h00, 0, 0, 0, 0, 1);
        cyc(1, 0, 8'h00, 8'd20, 8'h00, 0, 0, 0, 0, 1);
        rd(8'h00);
        rd(8'h00);
        wr(8'h00, 8'd55, 8'h00);
        rd(8'h00);

        wr(8'h01, 8'b0010_0011, 8'h01);
        cyc(0, 1, 8'h01, 8'hFF, 8'h01, 1, 1, 1, 1, 1);
        rd(8'h01);
        rd(8'h10);

        wr(8'h01, 8'b0010_0000, 8'h01);
        wr(8'hF5, 8'd7, 8'hF5);
        wr(8'h01, 8'h00, 8'hF5);
        rd(8'hF5);
        wr(8'hF5, 8'd9, 8'hF5);
        wr(8'h01, 8'b0010_0000, 8'hF5);
        rd(8'hF5);
        wr(8'h01, 8'b0110_0000, 8'hF5);
        wr(8'hF5, 8'd3, 8'hF5);
        wr(8'h01, 8'b0010_0000, 8'hF5);
        rd(8'hF5);

        for (int i = 0; i < 2000; i++) begin
            logic       rn, we, aw;
            logic [7:0] wa, wd;
            rn = ($urandom_range(0, 63) != 0);
            we = ($urandom_range(0, 2) != 0);
            aw = ($urandom_range(0, 7) == 0);
            wa = pick_addr();
            wd = 8'($urandom);
            cyc(rn, we, wa, wd, pick_addr(), ($urandom_range(0, 3) == 0), 1'($urandom),
                ($urandom_range(0, 3) == 0), 1'($urandom), aw);
        end

        rd(8'h00);
        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_banked.md
Name: mem_ctrl_banked

Overview:
- Data-memory controller for the 8-bit core.
- Holds the banked data RAM, the STATUS register (zero flag, carry flag, bank select) and the accumulator.
- Sits between the execute stage and storage: one write port and one read port (8-bit addresses), flag update inputs from the ALU, and a dedicated accumulator load.

Parameters:
- BANK_BITS, 2, width of the bank-select field. Gives 2^BANK_BITS banks of 256 bytes. Legal values 1..2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- zin  in  1  new zero-flag value
- z_write  in  1  load STATUS[0] from zin
- cin  in  1  new carry-flag value
- c_write  in  1  load STATUS[1] from cin
- cout  out  1  current carry flag, STATUS[1]
- writeaddr  in  8  write address
- writedata  in  8  write data; also the accumulator load data
- write_en  in  1  memory/register write strobe
- readaddr  in  8  read address
- readdata  out  8  read data
- accum_write  in  1  load accumulator from writedata
- accum_out  out  8  accumulator value

Behaviour:
- Address map, per port:
  - 0x00 = accumulator (ACC)
  - 0x01 = STATUS, unbanked
  - 0x02–0xFF = RAM at index {bank, addr}, bank = STATUS[4+BANK_BITS:5]
- STATUS layout:
  - bit0 Z
  - bit1 C
  - bits[4+BANK_BITS:5] bank select
  - all other bits unimplemented: ignore writes, read 0
- Writes, all on rising clk edge:
  - write_en=1 stores writedata at writeaddr, in the bank current before the edge.
  - Writing 0x01 updates Z, C and bank together.
- Flag writes:
  - z_write=1 sets Z := zin; c_write=1 sets C := cin.
  - These override the corresponding bit of a same-cycle STATUS write.
  - The bank bits still come from writedata.
- Accumulator:
  - accum_write=1 loads ACC := writedata.
  - It overrides a same-cycle write_en to 0x00.
- Reads:
  - readdata is combinational from current state at readaddr, using the current bank.
  - A write lands at the edge and is visible on readdata immediately after it, so zero cycles after the edge.
  - A bank switch retargets readdata at the edge with no extra latency.
- Outputs: cout and accum_out are direct register outputs.
- Reset (rst_n=0 at an edge): STATUS=0x00 (bank 0, Z=0, C=0), ACC=0x00. Reset overrides all same-cycle writes.
- RAM contents are not reset; they are X until written.
- Banks are fully independent: a write in bank n never alters bank m.

Optional Feature:
- Macro COMMON_RAM_EN.
- When defined: addresses 0xF0–0xFF always map to bank 0 RAM, whatever the bank select. This gives a 16-byte common area shared across banks, for both read and write.
- When undefined: 0xF0–0xFF are banked like the rest of the RAM.

Test Plan:
- Reset, then write 0x10 := 32 in bank 0. Read 0x10 the next cycle → 32. Rewrite 0x10 := 31 with readaddr=0x10 → readdata=31 one edge later.
- Write 0x01 := 0b00100010 → cout=1, bank 1. Write 0x10 := 12 → read 12. Write 0x01 := 0 → read 0x10 = 31. Write 0x01 := 0b00100000 → read 0x10 = 12.
- c_write=1, cin=1 → cout=1. Then z_write=1, zin=1, readaddr=0x01 → readdata=0b00100011.
- Same edge: write_en to 0x01 with 0x00, plus c_write=1, cin=1 → STATUS=0x02 (flag input wins).
- accum_write=1, writedata=20 → accum_out=20, held after accum_write=0. readaddr=0x00 → 20.
- Mid-run rst_n=0 for one edge → STATUS=0, cout=0, accum_out=0, bank 0.
- With COMMON_RAM_EN: write 0xF5 := 7 in bank 1, switch to bank 0 → read 0xF5 = 7.
- Without COMMON_RAM_EN: write 0xF5 := 7 in bank 1, write 0xF5 := 9 in bank 0 → bank 1 still reads 7.
